fp_norm_round: RTL and testbench
================================

Name: fp_norm_round

Overview:
- Post-arithmetic stage placed directly downstream of the FP adder/subtractor datapath.
- Accepts the un-normalized result: sign, larger exponent, and extended mantissa with guard/round/sticky.
- Normalizes over multiple cycles (right by 1 on carry, left by leading-zero count), applies round-to-nearest-even, handles overflow/underflow, and emits a packed IEEE-754 single.
- Uses a valid/ready handshake on both sides.

Parameters:
NORM_STEP, 8, maximum left-shift positions applied per NORM cycle; power of two, 1..32

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  upstream result valid
o_ready  output  1  stage can accept (high only in IDLE)
i_sign  input  1  result sign
i_exp  input  8  biased larger exponent of operands
i_mant  input  27  bit26 carry, bit25 hidden, bits24:2 fraction, bit1 guard, bit0 round
i_sticky  input  1  OR of bits shifted out upstream
o_valid  output  1  result valid (DONE state)
i_ready  input  1  downstream accepts
o_result  output  32  {sign, exp[7:0], frac[22:0]}
o_flags  output  3  {overflow, underflow, inexact}

Behaviour:
- Reset: applied synchronously when i_rst_n is low at a rising edge of i_clk; overrides everything, including an operation in progress, whose data is discarded.
  - State = IDLE, o_valid = 0, o_result = 0, o_flags = 0, internal registers = 0.
  - o_ready = 1 in the first cycle after reset release.
- Internal exponent: 10-bit signed (e), loaded as zero-extended i_exp.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid & o_ready: capture sign, e, mant, sticky; go to NORM.
- NORM, evaluated in priority order:
  1. mant == 0 and sticky == 0: result +0 (sign forced 0), flags 000, go to DONE.
  2. mant[26] = 1: mant >>= 1, sticky |= old mant[0], e += 1, go to ROUND.
  3. mant[25] = 1: go to ROUND.
  4. Otherwise compute lz = leading zeros counted from bit25, and s = min(lz, NORM_STEP).
     - If e - s < 1: flush to signed zero (exp 0, frac 0, keep sign), flags {0,1,1}, go to DONE.
     - Else: mant <<= s (zero-fill), e -= s, stay in NORM.
- ROUND:
  - g = mant[1], r = mant[0] | sticky, lsb = mant[2].
  - inc = g & (r | lsb); inexact = g | r.
  - mant[26:2] += inc. If the add carries into bit26: shift right 1, e += 1.
  - e >= 255: result ±inf (exp FF, frac 0), flags {1,0,1}.
  - Else: exp = e[7:0], frac = mant[24:2], flags {0,0,inexact}.
  - Go to DONE.
- DONE:
  - o_valid = 1; o_result and o_flags held stable.
  - On i_ready: o_valid falls next cycle, go to IDLE.
  - No new input is accepted while in DONE (o_ready = 0).
- Latency, with acceptance at edge 0:
  - Normalized or carry input: NORM in cycle 1, ROUND in cycle 2, o_valid high in cycle 3.
  - Left-shift case: o_valid high in cycle 3 + ceil(lz/NORM_STEP).
- Throughput: one result per (latency + 1) cycles minimum.
- o_result and o_flags change only on entry to DONE or on reset.
- Denormals are not produced (flush-to-zero). i_exp = 0 is processed arithmetically with no special casing.

Test Plan:
- Normalized input: sign 0, exp 127, mant 27'h2000000, sticky 0 -> o_result 32'h3F800000, flags 000, o_valid in cycle 3 after acceptance.
- Carry input: exp 127, mant 27'h4000000 -> 32'h40000000, flags 000, latency 3.
- Tie to even, lsb 0: exp 127, mant 27'h2000002 -> 32'h3F800000, inexact only.
- Tie to even, lsb 1: exp 127, mant 27'h2000006 -> 32'h3F800002, inexact only.
- Cancellation: exp 127, mant 27'h0000008, NORM_STEP 8 (lz = 22) -> 32'h34800000, flags 000, o_valid in cycle 6.
- Underflow: exp 10 with the same mant -> 32'h00000000, flags 011.
- Overflow: exp 254, mant 27'h3FFFFFF -> round carry -> 32'h7F800000, flags 101.
- Handshake and reset: hold i_ready = 0 for 5 cycles in DONE -> o_result stable and o_ready = 0 throughout. Assert i_rst_n = 0 for 1 cycle during NORM -> IDLE, o_valid = 0, o_result = 0, o_ready = 1 the next cycle. Exact zero (mant 0, sign 1) -> 32'h00000000.

Source files
------------

// File: rtl/fp_norm_round.sv
// Post-add normalize/round stage: takes the raw adder result, normalizes it over
// several cycles, rounds to nearest-even and packs an IEEE-754 single.
module fp_norm_round #(
  parameter int NORM_STEP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_sign,
  input  logic [7:0]  i_exp,
  input  logic [26:0] i_mant,
  input  logic        i_sticky,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [2:0]  o_flags
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

  state_e             state_q;
  logic               sign_q;
  logic signed [9:0]  e_q;
  logic [26:0]        mant_q;
  logic               sticky_q;
  logic [31:0]        result_q;
  logic [2:0]         flags_q;

  logic [4:0]         lz;
  logic [5:0]         step;
  logic signed [10:0] e_shift_d;
  logic [26:0]        mant_shl_d;
  logic               rnd_inc;
  logic               rnd_inexact;
  logic [24:0]        rnd_sum;
  logic               rnd_carry;
  logic [22:0]        rnd_frac_d;
  logic signed [9:0]  e_rnd_d;
  logic               rnd_ovf;

  // NOTE: every signal gets a default before any conditional assignment in
  // always_comb, so no path can leave it unassigned and infer a latch.
  always_comb begin
    lz = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (mant_q[i]) lz = 5'(25 - i);
    end
    step       = (int'(lz) > NORM_STEP) ? 6'(NORM_STEP) : {1'b0, lz};
    e_shift_d  = {e_q[9], e_q} - {5'd0, step};
    mant_shl_d = mant_q << step;

    rnd_inc     = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
    rnd_inexact = mant_q[1] | mant_q[0] | sticky_q;
    // mant_q[26] is always clear in ROUND, so the 25-bit sum cannot wrap.
    rnd_sum     = mant_q[26:2] + {24'd0, rnd_inc};
    rnd_carry   = rnd_sum[24];
    rnd_frac_d  = rnd_carry ? rnd_sum[23:1] : rnd_sum[22:0];
    e_rnd_d     = e_q + {9'd0, rnd_carry};
    rnd_ovf     = (e_rnd_d >= 10'sd255);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      e_q      <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            sign_q   <= i_sign;
            e_q      <= {2'b00, i_exp};
            mant_q   <= i_mant;
            sticky_q <= i_sticky;
            state_q  <= NORM;
          end
        end
        NORM: begin
          if (mant_q == '0 && !sticky_q) begin
            result_q <= '0;
            flags_q  <= 3'b000;
            state_q  <= DONE;
          end else if (mant_q[26]) begin
            mant_q   <= mant_q >> 1;
            sticky_q <= sticky_q | mant_q[0];
            e_q      <= e_q + 10'sd1;
            state_q  <= ROUND;
          end else if (mant_q[25]) begin
            state_q  <= ROUND;
          end else if (e_shift_d < 11'sd1) begin
            // Would go subnormal: flush to signed zero.
            result_q <= {sign_q, 31'd0};
            flags_q  <= 3'b011;
            state_q  <= DONE;
          end else begin
            mant_q   <= mant_shl_d;
            e_q      <= e_shift_d[9:0];
          end
        end
        ROUND: begin
          if (rnd_ovf) begin
            result_q <= {sign_q, 8'hFF, 23'd0};
            flags_q  <= 3'b101;
          end else begin
            result_q <= {sign_q, e_rnd_d[7:0], rnd_frac_d};
            flags_q  <= {2'b00, rnd_inexact};
          end
          state_q <= DONE;
        end
        DONE: begin
          if (i_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed vectors push expected results,
// a negedge monitor pops and compares result, flags and latency.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [26:0] i_mant;
  logic        i_sticky;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [2:0]  o_flags;

  fp_norm_round #(.NORM_STEP(8)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sign   (i_sign),
    .i_exp    (i_exp),
    .i_mant   (i_mant),
    .i_sticky (i_sticky),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flags  (o_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   taken    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one comparison set per DONE episode.
  always @(negedge clk) begin
    if (!o_valid) begin
      taken = 1'b0;
    end else if (!taken) begin
      exp_t e;
      taken = 1'b1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got result %h with nothing outstanding", o_result);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_result"},  o_result, e.res);
        check({e.tag, "_flags"},   {29'd0, o_flags}, {29'd0, e.flags});
        check({e.tag, "_latency"}, cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic drive(input bit s, input logic [7:0] ex, input logic [26:0] m, input bit st);
    i_sign   = s;
    i_exp    = ex;
    i_mant   = m;
    i_sticky = st;
    i_valid  = 1'b1;
  endtask

  task automatic send(input string tag, input bit s, input logic [7:0] ex,
                      input logic [26:0] m, input bit st,
                      input logic [31:0] res, input logic [2:0] fl, input int lat);
    exp_t e;
    int   tries = 0;
    @(negedge clk);
    drive(s, ex, m, st);
    while (!o_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (!o_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept: o_ready stayed 0, expected 1 within 100 cycles", tag);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    e.tag = tag; e.res = res; e.flags = fl; e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || o_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || o_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_sign   = 1'b0;
    i_exp    = '0;
    i_mant   = '0;
    i_sticky = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_o_valid",  o_valid, 0);
    check("reset_o_ready",  o_ready, 1);
    check("reset_o_result", o_result, 32'h0);
    check("reset_o_flags",  {29'd0, o_flags}, 0);

    // Back-to-back directed vectors with i_ready held high.
    send("normalized",   0, 8'd127, 27'h2000000, 0, 32'h3F800000, 3'b000, 3);
    send("carry",        0, 8'd127, 27'h4000000, 0, 32'h40000000, 3'b000, 3);
    send("tie_even_lsb0",0, 8'd127, 27'h2000002, 0, 32'h3F800000, 3'b001, 3);
    send("tie_even_lsb1",0, 8'd127, 27'h2000006, 0, 32'h3F800002, 3'b001, 3);
    send("sticky_up",    0, 8'd127, 27'h2000002, 1, 32'h3F800001, 3'b001, 3);
    send("carry_sticky", 0, 8'd127, 27'h4000003, 0, 32'h40000000, 3'b001, 3);
    send("round_carry",  0, 8'd127, 27'h3FFFFFE, 0, 32'h40000000, 3'b001, 3);
    send("negative",     1, 8'd130, 27'h2400000, 0, 32'hC1100000, 3'b000, 3);
    send("cancel",       0, 8'd127, 27'h0000008, 0, 32'h34800000, 3'b000, 6);
    send("underflow",    0, 8'd10,  27'h0000008, 0, 32'h00000000, 3'b011, 3);
    send("overflow",     0, 8'd254, 27'h3FFFFFF, 0, 32'h7F800000, 3'b101, 3);
    send("exact_zero",   1, 8'd127, 27'h0000000, 0, 32'h00000000, 3'b000, 2);
    send("sticky_only",  1, 8'd127, 27'h0000000, 1, 32'h80000000, 3'b011, 17);
    drain("directed");

    // Downstream stall: output must hold while i_ready is low.
    i_ready = 1'b0;
    send("stall", 1, 8'd130, 27'h2400000, 0, 32'hC1100000, 3'b000, 3);
    begin
      int n = 0;
      while (!o_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_o_result", o_result, 32'hC1100000);
      check("stall_o_ready",  o_ready, 0);
      check("stall_o_valid",  o_valid, 1);
    end
    i_ready = 1'b1;
    drain("stall");

    // Reset in the middle of NORM discards the operation.
    @(negedge clk);
    drive(0, 8'd127, 27'h0000008, 0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_o_valid",  o_valid, 0);
    check("midreset_o_ready",  o_ready, 1);
    check("midreset_o_result", o_result, 32'h0);
    check("midreset_o_flags",  {29'd0, o_flags}, 0);

    send("after_reset", 0, 8'd127, 27'h2000000, 0, 32'h3F800000, 3'b000, 3);
    drain("after_reset");
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
